// File: rtl/bn_mux3_arbiter.sv
// Round-robin burst arbiter sharing one BN operand bus among three requesters,
// with a registered valid/ready output stage toward the systolic array.
module bn_mux3_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            in_valid,
  input  logic [2:0]            in_last,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic [DATA_WIDTH-1:0] in2_data,
  output logic [2:0]            in_ready,
  output logic [1:0]            mux_sel,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [1:0]            out_src,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int unsigned CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [1:0]  SEL_IDLE = 2'b11;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q, state_d;
  logic [1:0]            sel_q, sel_d;
  logic [1:0]            last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ov_q, ov_d;
  logic [DATA_WIDTH-1:0] od_q, od_d;
  logic                  ol_q, ol_d;
  logic [1:0]            os_q, os_d;

  logic [DATA_WIDTH-1:0] mux_data;
  logic [3:0]            valid4, last4;
  logic                  g_valid, g_last, slot_free, xfer, burst_end;
  logic [1:0]            cand1, cand2, winner;

  function automatic logic [1:0] next_req(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Operand mux; the idle select drives zero.
  always_comb begin
    mux_data = '0;
    case (sel_q)
      2'd0:    mux_data = in0_data;
      2'd1:    mux_data = in1_data;
      2'd2:    mux_data = in2_data;
      default: mux_data = '0;
    endcase
  end

  // Padding to 4 bits lets the idle select read as "no request".
  assign valid4    = {1'b0, in_valid};
  assign last4     = {1'b0, in_last};
  assign g_valid   = valid4[sel_q];
  assign g_last    = last4[sel_q];
  assign slot_free = !ov_q || out_ready;
  assign xfer      = (state_q == BUSY) && g_valid && slot_free;
  assign burst_end = g_last || (cnt_q == CNT_W'(BURST_LEN - 1));

  assign cand1  = next_req(last_grant_q);
  assign cand2  = next_req(cand1);
  assign winner = valid4[cand1] ? cand1 : (valid4[cand2] ? cand2 : last_grant_q);

  always_comb begin
    in_ready = 3'b000;
    if (state_q == BUSY && slot_free) begin
      case (sel_q)
        2'd0:    in_ready = 3'b001;
        2'd1:    in_ready = 3'b010;
        2'd2:    in_ready = 3'b100;
        default: in_ready = 3'b000;
      endcase
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    ov_d         = ov_q;
    od_d         = od_q;
    ol_d         = ol_q;
    os_d         = os_q;
    if (ov_q && out_ready) ov_d = 1'b0;
    case (state_q)
      IDLE: begin
        sel_d = SEL_IDLE;
        if (|in_valid) begin
          state_d      = BUSY;
          sel_d        = winner;
          last_grant_d = winner;
          cnt_d        = '0;
        end
      end
      BUSY: begin
        if (xfer) begin
          ov_d  = 1'b1;
          od_d  = mux_data;
          os_d  = sel_q;
          ol_d  = burst_end;
          cnt_d = cnt_q + CNT_W'(1);
          if (burst_end) begin
            state_d = IDLE;
            sel_d   = SEL_IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= SEL_IDLE;
      last_grant_q <= 2'd2;
      cnt_q        <= '0;
      ov_q         <= 1'b0;
      od_q         <= '0;
      ol_q         <= 1'b0;
      os_q         <= SEL_IDLE;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      ov_q         <= ov_d;
      od_q         <= od_d;
      ol_q         <= ol_d;
      os_q         <= os_d;
    end
  end

  assign mux_sel   = sel_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_last  = ol_q;
  assign out_src   = os_q;
  assign busy      = (state_q == BUSY);

endmodule
